lcb_responder: RTL and testbench

- Slave end of the RS-485 request/response link: plays the local commutation block (LCB) that answers the orbital frame unit's requests.
- Receives a fixed-length 8N1 request frame and checks the device address.
- On a match, it reads RESP_BYTES bytes from a data source through a ROM-style port and transmits them back with RS-485 direction control.
- Used as an on-board LCB emulator for bench and loopback testing of the receive/writer/FIFO/packer chain.

---
 rtl/lcb_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_lcb_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcb_responder.sv
// LCB emulator: receives a fixed-length 8N1 request and, on an address match, streams
// RESP_BYTES bytes from a ROM-style source back over RS-485 with direction control.
module lcb_responder #(
    parameter int         BIT_DIV    = 16,
    parameter int         RQ_BYTES   = 4,
    parameter int         RESP_BYTES = 16,
    parameter logic [7:0] DEV_ADDR   = 8'h15,
    parameter int         TURN_BITS  = 4,
    parameter int         GAP_BITS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic       dirTX,
    output logic       dirRX,
    output logic [7:0] rdAddr,
    output logic       rdEn,
    input  logic [7:0] rdData,
    output logic       busy,
    output logic       frameOk,
    output logic       frameErr
);

    localparam int TURN_TICKS = TURN_BITS * BIT_DIV;
    localparam int GAP_TICKS  = GAP_BITS * BIT_DIV;
    localparam int TW = $clog2((TURN_TICKS > BIT_DIV) ? TURN_TICKS : BIT_DIV) + 1;
    localparam int GW = $clog2(GAP_TICKS) + 1;
    localparam int CW = $clog2(RQ_BYTES + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BIT_DIV / 2 - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_TICKS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] RQ_LAST   = CW'(RQ_BYTES - 1);
    localparam logic [4:0]    RESP_LAST = 5'(RESP_BYTES - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rxState_t;
    typedef enum logic [2:0] {M_LISTEN, M_TURN, M_PRE, M_TX, M_REL} mainState_t;

    rxState_t   rxState, rxNext;
    mainState_t mainState, mainNext;

    logic          rxMeta, rxSync, rxPrev;
    logic [TW-1:0] rxTmr;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift, addrByte, startIdx;
    logic [CW-1:0] rqCnt;
    logic [GW-1:0] gapTmr;
    logic          byteDone, stopBad, gapHit, rqLast, match;

    logic [TW-1:0] tmr;
    logic [3:0]    bitIdx;
    logic [4:0]    byteCnt;
    logic [9:0]    txShift;
    logic [7:0]    txByte;
    logic          rdValid, tick;

    // ---------------- receiver ----------------
    // The receiver is blind while a response is in progress.
    always_comb begin
        rxNext   = rxState;
        byteDone = 1'b0;
        stopBad  = 1'b0;
        case (rxState)
            R_IDLE:   if (mainState == M_LISTEN && rxPrev && !rxSync) rxNext = R_START;
            R_START:  if (rxTmr == HALF_LAST) rxNext = rxSync ? R_IDLE : R_DATA;
            R_DATA:   if (rxTmr == BIT_LAST && rxBit == 3'd7) rxNext = R_STOP;
            R_STOP: begin
                if (rxTmr == BIT_LAST) begin
                    if (rxSync) begin
                        rxNext   = R_IDLE;
                        byteDone = 1'b1;
                    end else begin
                        rxNext  = R_WAITHI;
                        stopBad = 1'b1;
                    end
                end
            end
            R_WAITHI: if (rxSync) rxNext = R_IDLE;
            default:  rxNext = R_IDLE;
        endcase
    end

    assign gapHit = (rxState == R_IDLE) && (rqCnt != '0) && (gapTmr == GAP_LAST);
    assign rqLast = byteDone && (rqCnt == RQ_LAST);
    assign match  = rqLast && (addrByte == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxMeta   <= 1'b1;
            rxSync   <= 1'b1;
            rxPrev   <= 1'b1;
            rxState  <= R_IDLE;
            rxTmr    <= '0;
            rxBit    <= '0;
            rxShift  <= '0;
            rqCnt    <= '0;
            addrByte <= '0;
            startIdx <= '0;
            gapTmr   <= '0;
            frameOk  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxMeta   <= rx;
            rxSync   <= rxMeta;
            rxPrev   <= rxSync;
            rxState  <= rxNext;
            frameOk  <= match;
            frameErr <= stopBad || gapHit;

            if (rxNext != rxState || (rxState == R_DATA && rxTmr == BIT_LAST))
                rxTmr <= '0;
            else
                rxTmr <= rxTmr + 1'b1;

            if (rxState == R_START)
                rxBit <= '0;
            else if (rxState == R_DATA && rxTmr == BIT_LAST) begin
                rxShift <= {rxSync, rxShift[7:1]};
                rxBit   <= rxBit + 1'b1;
            end

            if (rxState == R_IDLE && rqCnt != '0 && !gapHit)
                gapTmr <= gapTmr + 1'b1;
            else
                gapTmr <= '0;

            if (stopBad || gapHit)
                rqCnt <= '0;
            else if (byteDone) begin
                if (rqCnt == CW'(0)) addrByte <= rxShift;
                if (rqCnt == CW'(1)) startIdx <= rxShift;
                rqCnt <= rqLast ? '0 : rqCnt + 1'b1;
            end
        end
    end

    // ---------------- responder ----------------
    assign tick = (tmr == BIT_LAST);

    always_comb begin
        mainNext = mainState;
        tx       = 1'b1;
        dirTX    = 1'b0;
        busy     = 1'b1;
        case (mainState)
            M_LISTEN: begin
                busy = 1'b0;
                if (match) mainNext = M_TURN;
            end
            M_TURN: if (tmr == TURN_LAST) mainNext = M_PRE;
            M_PRE: begin
                dirTX = 1'b1;
                if (tick) mainNext = M_TX;
            end
            M_TX: begin
                dirTX = 1'b1;
                tx    = txShift[0];
                if (tick && bitIdx == 4'd9 && byteCnt == RESP_LAST) mainNext = M_REL;
            end
            M_REL: begin
                dirTX = 1'b1;
                if (tick) mainNext = M_LISTEN;
            end
            default: begin
                busy     = 1'b0;
                mainNext = M_LISTEN;
            end
        endcase
    end

    assign dirRX = ~dirTX;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mainState <= M_LISTEN;
            tmr       <= '0;
            bitIdx    <= '0;
            byteCnt   <= '0;
            txShift   <= '1;
            txByte    <= '0;
            rdValid   <= 1'b0;
            rdEn      <= 1'b0;
            rdAddr    <= '0;
        end else begin
            mainState <= mainNext;
            rdEn      <= 1'b0;
            rdValid   <= rdEn;
            if (rdValid) txByte <= rdData;

            if (mainNext != mainState || (mainState == M_TX && tick))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            case (mainState)
                M_TURN: begin
                    if (mainNext == M_PRE) begin
                        rdEn   <= 1'b1;
                        rdAddr <= startIdx;
                    end
                end
                M_PRE: begin
                    if (tick) begin
                        txShift <= {1'b1, txByte, 1'b0};
                        bitIdx  <= '0;
                        byteCnt <= '0;
                    end
                end
                M_TX: begin
                    if (tick) begin
                        if (bitIdx == 4'd9) begin
                            // Next byte follows the stop bit with no idle gap.
                            bitIdx  <= '0;
                            byteCnt <= byteCnt + 1'b1;
                            txShift <= {1'b1, txByte, 1'b0};
                        end else begin
                            bitIdx  <= bitIdx + 1'b1;
                            txShift <= {1'b1, txShift[9:1]};
                            if (bitIdx == 4'd8 && byteCnt != RESP_LAST) begin
                                rdEn   <= 1'b1;
                                rdAddr <= rdAddr + 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcb_responder.sv
// Bench for lcb_responder: drives 8N1 requests, decodes the tx stream and compares
// bytes, addresses and timing against a simple model of the request/response rules.
module tb_lcb_responder;

    localparam int         BIT_DIV    = 16;
    localparam int         RESP_BYTES = 16;
    localparam logic [7:0] DEV_ADDR   = 8'h15;
    localparam int         TURN_CLKS  = 4 * BIT_DIV;
    localparam int         RESP_CLKS  = (1 + 10 * RESP_BYTES + 1) * BIT_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       tx, dirTX, dirRX, rdEn, busy, frameOk, frameErr;
    logic [7:0] rdAddr;
    logic [7:0] rdData = 8'h00;

    lcb_responder dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .dirTX(dirTX), .dirRX(dirRX),
        .rdAddr(rdAddr), .rdEn(rdEn), .rdData(rdData), .busy(busy),
        .frameOk(frameOk), .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    int nChk = 0, nFail = 0;
    int cyc = 0;
    int okCnt, errCnt, riseCnt, idleLow, dirBad, stopBits;
    int okTime, riseTime, fallTime, busyRise;
    logic dirPrev = 1'b0, busyPrev = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] txQ[$];
    logic [7:0] addrQ[$];
    logic [7:0] monByte;
    logic [7:0] ra, rs;

    // Data source: registered ROM read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdEn) begin
            rdData <= mem[rdAddr];
            addrQ.push_back(rdAddr);
        end
    end

    // Event / line monitor.
    initial forever begin
        @(negedge clk);
        if (frameOk)  begin okCnt++; okTime = cyc; end
        if (frameErr) errCnt++;
        if (dirTX && !dirPrev) begin riseCnt++; riseTime = cyc; end
        if (!dirTX && dirPrev) fallTime = cyc;
        if (busy && !busyPrev) busyRise = cyc;
        if (!dirTX && tx !== 1'b1) idleLow++;
        if (dirRX !== ~dirTX) dirBad++;
        dirPrev  = dirTX;
        busyPrev = busy;
    end

    // UART decoder on the response line.
    initial forever begin
        @(negedge clk);
        if (dirTX === 1'b1 && tx === 1'b0) begin
            repeat (BIT_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_DIV) @(negedge clk);
                monByte[i] = tx;
            end
            repeat (BIT_DIV) @(negedge clk);
            if (tx !== 1'b1) stopBits++;
            txQ.push_back(monByte);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        nChk++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitTime(input logic v);
        rx = v;
        idle(BIT_DIV);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        bitTime(1'b0);
        for (int i = 0; i < 8; i++) bitTime(b[i]);
        bitTime(stopBit);
        rx = 1'b1;
    endtask

    task automatic sendReq(input logic [7:0] a, s, b2, b3);
        sendByte(a, 1'b1);
        sendByte(s, 1'b1);
        sendByte(b2, 1'b1);
        sendByte(b3, 1'b1);
    endtask

    task automatic clearMon();
        okCnt = 0; errCnt = 0; riseCnt = 0; idleLow = 0; dirBad = 0; stopBits = 0;
        okTime = -1; riseTime = -1; fallTime = -1; busyRise = -1;
        txQ.delete();
        addrQ.delete();
    endtask

    // Model: a request is answered iff byte0 equals the device address; the answer is
    // mem[startIdx + i] for i = 0..RESP_BYTES-1 with the address wrapping at 8 bits.
    task automatic runReq(input string tag, input logic [7:0] a, s, b2, b3);
        logic       expResp;
        logic [7:0] ea;
        clearMon();
        expResp = (a == DEV_ADDR);
        sendReq(a, s, b2, b3);
        idle(TURN_CLKS + RESP_CLKS + 200);
        check({tag, ".err"}, errCnt, 0);
        check({tag, ".idleLow"}, idleLow, 0);
        check({tag, ".dirRX"}, dirBad, 0);
        check({tag, ".endIdle"}, {busy, dirTX, tx}, 3'b001);
        if (expResp) begin
            check({tag, ".ok"}, okCnt, 1);
            check({tag, ".rise"}, riseCnt, 1);
            check({tag, ".turn"}, riseTime - okTime, TURN_CLKS);
            check({tag, ".dur"}, fallTime - riseTime, RESP_CLKS);
            check({tag, ".busyRise"}, busyRise, okTime);
            check({tag, ".stop"}, stopBits, 0);
            check({tag, ".nBytes"}, txQ.size(), RESP_BYTES);
            check({tag, ".nAddr"}, addrQ.size(), RESP_BYTES);
            for (int i = 0; i < txQ.size(); i++) begin
                ea = s + 8'(i);
                check($sformatf("%s.byte%0d", tag, i), txQ[i], mem[ea]);
            end
            for (int i = 0; i < addrQ.size(); i++) begin
                ea = s + 8'(i);
                check($sformatf("%s.addr%0d", tag, i), addrQ[i], ea);
            end
        end else begin
            check({tag, ".noOk"}, okCnt, 0);
            check({tag, ".noRise"}, riseCnt, 0);
            check({tag, ".noBytes"}, txQ.size() + addrQ.size(), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
        clearMon();

        // Reset values
        rst = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst.tx", tx, 1);
        check("rst.dir", {dirTX, dirRX}, 2'b01);
        check("rst.rd", {rdEn, rdAddr}, 0);
        check("rst.flags", {busy, frameOk, frameErr}, 0);
        rst = 1'b1;
        idle(10);

        // Matching request, data = addr + 0x40
        runReq("match", 8'h15, 8'h03, 8'h00, 8'h00);
        // Wrong address: silent discard
        runReq("wrongAddr", 8'h16, 8'h03, 8'h00, 8'h00);

        // Gap timeout inside a request, then a normal request
        clearMon();
        sendByte(8'h15, 1'b1);
        sendByte(8'h03, 1'b1);
        idle(20 * BIT_DIV);
        check("gap.err1", errCnt, 1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h00, 1'b1);
        idle(20 * BIT_DIV + 80);
        check("gap.err2", errCnt, 2);
        check("gap.noResp", okCnt + riseCnt, 0);
        runReq("afterGap", 8'h15, 8'h00, 8'h00, 8'h00);

        // Bad stop bit on byte 1 clears the byte count
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        clearMon();
        sendByte(8'h15, 1'b1);
        sendByte(8'h03, 1'b0);
        idle(2 * BIT_DIV);
        check("stop.err", errCnt, 1);
        check("stop.noResp", okCnt + riseCnt, 0);
        runReq("afterStop", 8'h15, 8'($urandom), 8'h00, 8'h00);

        // Short glitch on rx is ignored
        clearMon();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * BIT_DIV);
        check("glitch.err", errCnt, 0);
        check("glitch.ok", okCnt, 0);

        // Address wrap
        runReq("wrap", 8'h15, 8'hF8, 8'h5A, 8'hA5);

        // Randomised requests
        for (int k = 0; k < 4; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? DEV_ADDR : 8'($urandom);
            rs = 8'($urandom);
            runReq($sformatf("rand%0d", k), ra, rs, 8'($urandom), 8'($urandom));
        end

        // Reset during the 5th response byte
        clearMon();
        sendReq(8'h15, 8'($urandom), 8'h00, 8'h00);
        for (int i = 0; i < 200 && dirTX !== 1'b1; i++) @(negedge clk);
        check("rstMid.rise", dirTX, 1);
        idle(BIT_DIV + 4 * 10 * BIT_DIV + 5 * BIT_DIV);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstMid.tx", tx, 1);
        check("rstMid.dir", {dirTX, dirRX}, 2'b01);
        check("rstMid.busy", busy, 0);
        rst = 1'b1;
        idle(12 * BIT_DIV);
        runReq("afterRst", 8'h15, 8'($urandom), 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
